// File: rtl/conv_pkg.sv
// Shared types and helpers for the convolution sequencer.
package conv_pkg;

   typedef enum logic [2:0] {
      IDLE,
      CLEAR,
      MAC,
      DRAIN,
      OUT,
      DONE
   } conv_state_t;

   // Number of valid (non-padded) outputs of a convolution of an x vector with an f filter.
   function automatic int n_out(input int x, input int f);
      return x - f + 1;
   endfunction

endpackage

// File: rtl/conv_seq_ctrl_valid_delay_line.sv
// Delay line that turns the read-issue strobe into the accumulate enable,
// so that the MAC only accumulates once the memory data has arrived.
module valid_delay_line #(
   parameter int DEPTH = 1
) (
   input  logic clk,
   input  logic reset,
   input  logic valid_i,
   output logic valid_o
);

   logic [DEPTH-1:0] pipe_q;
   logic [DEPTH-1:0] pipe_d;

   // Shift every stage one place along; stage 0 takes the new strobe.
   always_comb begin
      pipe_d    = '0;
      pipe_d[0] = valid_i;
      for (int i = 1; i < DEPTH; i++) begin
         pipe_d[i] = pipe_q[i-1];
      end
   end

   // Pipeline register; reset flushes any in-flight strobes.
   always_ff @(posedge clk) begin
      if (reset) begin
         pipe_q <= '0;
      end else begin
         pipe_q <= pipe_d;
      end
   end

   assign valid_o = pipe_q[DEPTH-1];

endmodule

// File: rtl/conv_seq_ctrl.sv
// Convolution sequencer: waits for both memories to be loaded, walks every
// output position issuing x/f reads, lines up the accumulator controls with
// the read latency, hands each result out on the y stream and finally
// releases the memories for the next vector pair.
module conv_seq_ctrl
   import conv_pkg::*;
#(
   parameter int X_MEM_SIZE       = 8,
   parameter int F_MEM_SIZE       = 4,
   parameter int X_MEM_ADDR_WIDTH = 3,
   parameter int F_MEM_ADDR_WIDTH = 2,
   parameter int RD_LAT           = 1
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        x_loaded,
   input  logic                        f_loaded,
   output logic                        release_mem,
   output logic [X_MEM_ADDR_WIDTH-1:0] x_rd_addr,
   output logic [F_MEM_ADDR_WIDTH-1:0] f_rd_addr,
   output logic                        reset_accum,
   output logic                        en_accum,
   output logic                        m_valid_y,
   input  logic                        m_ready_y,
   output logic                        conv_done
);

   localparam int N_OUT = n_out(X_MEM_SIZE, F_MEM_SIZE);
   localparam logic [X_MEM_ADDR_WIDTH-1:0] LAST_OUT   = X_MEM_ADDR_WIDTH'(N_OUT - 1);
   localparam logic [F_MEM_ADDR_WIDTH-1:0] LAST_TAP   = F_MEM_ADDR_WIDTH'(F_MEM_SIZE - 1);
   localparam logic [2:0]                  LAST_DRAIN = 3'(RD_LAT - 1);

   conv_state_t                 state_q,      state_d;
   logic [X_MEM_ADDR_WIDTH-1:0] outIdx_q,     outIdx_d;
   logic [F_MEM_ADDR_WIDTH-1:0] tap_q,        tap_d;
   logic [2:0]                  drainCnt_q,   drainCnt_d;
   logic [X_MEM_ADDR_WIDTH-1:0] xAddr_q,      xAddr_d;
   logic [F_MEM_ADDR_WIDTH-1:0] fAddr_q,      fAddr_d;
   logic                        resetAccum_q, resetAccum_d;
   logic                        issue;

   // Next-state logic. Addresses are loaded one cycle ahead so that during
   // MAC cycle 'tap' the registered address already equals out_idx+tap.
   // The x sum is formed one bit wider than the address and then truncated;
   // it never wraps because out_idx+tap stays inside the x memory.
   always_comb begin
      state_d    = state_q;
      outIdx_d   = outIdx_q;
      tap_d      = tap_q;
      drainCnt_d = drainCnt_q;
      xAddr_d    = xAddr_q;
      fAddr_d    = fAddr_q;

      case (state_q)
         IDLE: begin
            if (x_loaded && f_loaded) begin
               state_d = CLEAR;
            end
         end
         CLEAR: begin
            tap_d   = '0;
            xAddr_d = outIdx_q;
            fAddr_d = '0;
            state_d = MAC;
         end
         MAC: begin
            if (tap_q == LAST_TAP) begin
               drainCnt_d = '0;
               state_d    = DRAIN;
            end else begin
               tap_d   = tap_q + F_MEM_ADDR_WIDTH'(1);
               fAddr_d = tap_q + F_MEM_ADDR_WIDTH'(1);
               xAddr_d = X_MEM_ADDR_WIDTH'({1'b0, outIdx_q}
                                           + (X_MEM_ADDR_WIDTH+1)'(tap_q)
                                           + (X_MEM_ADDR_WIDTH+1)'(1));
            end
         end
         DRAIN: begin
            if (drainCnt_q == LAST_DRAIN) begin
               state_d = OUT;
            end else begin
               drainCnt_d = drainCnt_q + 3'd1;
            end
         end
         OUT: begin
            if (m_ready_y) begin
               if (outIdx_q == LAST_OUT) begin
                  state_d = DONE;
               end else begin
                  outIdx_d = outIdx_q + X_MEM_ADDR_WIDTH'(1);
                  state_d  = CLEAR;
               end
            end
         end
         DONE: begin
            outIdx_d = '0;
            state_d  = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      resetAccum_d = (state_d == CLEAR);
   end

   // State, counters and registered outputs; reset returns everything to
   // IDLE immediately, abandoning any output in progress.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= IDLE;
         outIdx_q     <= '0;
         tap_q        <= '0;
         drainCnt_q   <= '0;
         xAddr_q      <= '0;
         fAddr_q      <= '0;
         resetAccum_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         outIdx_q     <= outIdx_d;
         tap_q        <= tap_d;
         drainCnt_q   <= drainCnt_d;
         xAddr_q      <= xAddr_d;
         fAddr_q      <= fAddr_d;
         resetAccum_q <= resetAccum_d;
      end
   end

   assign issue = (state_q == MAC);

   valid_delay_line #(
      .DEPTH (RD_LAT)
   ) uEnDelay (
      .clk     (clk),
      .reset   (reset),
      .valid_i (issue),
      .valid_o (en_accum)
   );

   assign x_rd_addr   = xAddr_q;
   assign f_rd_addr   = fAddr_q;
   assign reset_accum = resetAccum_q;
   assign m_valid_y   = (state_q == OUT);
   assign conv_done   = (state_q == DONE);
   assign release_mem = (state_q == DONE);

endmodule

// File: tb/tb_conv_seq_ctrl.sv
// Testbench for conv_seq_ctrl: default configuration plus an RD_LAT=3
// instance and a single-output (square) instance.
module tb_conv_seq_ctrl;

   logic clk = 1'b0;
   logic reset;
   int   cyc = 0;
   int   testsRun = 0;
   int   testsFailed = 0;

   // Default instance signals
   logic       xLoaded, fLoaded, mReady;
   logic       releaseMem, resetAccum, enAccum, mValid, convDone;
   logic [2:0] xRdAddr;
   logic [1:0] fRdAddr;

   // RD_LAT=3 instance signals
   logic       l3XLoaded, l3FLoaded, l3Ready;
   logic       l3Release, l3ResetAccum, l3EnAccum, l3Valid, l3Done;
   logic [2:0] l3XAddr;
   logic [1:0] l3FAddr;

   // X=F=4 instance signals
   logic       sqXLoaded, sqFLoaded, sqReady;
   logic       sqRelease, sqResetAccum, sqEnAccum, sqValid, sqDone;
   logic [1:0] sqXAddr;
   logic [1:0] sqFAddr;

   typedef struct {
      logic xl;
      logic fl;
      logic rdy;
      logic expReset;
      logic expEn;
      logic expValid;
      int   expX;
      int   expF;
   } vec_t;

   typedef struct {
      int xa;
      int fa;
   } issueRec_t;

   vec_t      vecs[18];
   issueRec_t issueQ[$];
   int        hsQ[$];
   bit        sbEnable = 1'b0;
   int        prevX = 0;
   int        prevF = 0;
   int        doneCount = 0;
   int        doneCyc = -1;
   int        releaseCount = 0;

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   conv_seq_ctrl dut (
      .clk         (clk),
      .reset       (reset),
      .x_loaded    (xLoaded),
      .f_loaded    (fLoaded),
      .release_mem (releaseMem),
      .x_rd_addr   (xRdAddr),
      .f_rd_addr   (fRdAddr),
      .reset_accum (resetAccum),
      .en_accum    (enAccum),
      .m_valid_y   (mValid),
      .m_ready_y   (mReady),
      .conv_done   (convDone)
   );

   conv_seq_ctrl #(.RD_LAT(3)) dutLat3 (
      .clk         (clk),
      .reset       (reset),
      .x_loaded    (l3XLoaded),
      .f_loaded    (l3FLoaded),
      .release_mem (l3Release),
      .x_rd_addr   (l3XAddr),
      .f_rd_addr   (l3FAddr),
      .reset_accum (l3ResetAccum),
      .en_accum    (l3EnAccum),
      .m_valid_y   (l3Valid),
      .m_ready_y   (l3Ready),
      .conv_done   (l3Done)
   );

   conv_seq_ctrl #(
      .X_MEM_SIZE       (4),
      .F_MEM_SIZE       (4),
      .X_MEM_ADDR_WIDTH (2),
      .F_MEM_ADDR_WIDTH (2),
      .RD_LAT           (1)
   ) dutSquare (
      .clk         (clk),
      .reset       (reset),
      .x_loaded    (sqXLoaded),
      .f_loaded    (sqFLoaded),
      .release_mem (sqRelease),
      .x_rd_addr   (sqXAddr),
      .f_rd_addr   (sqFAddr),
      .reset_accum (sqResetAccum),
      .en_accum    (sqEnAccum),
      .m_valid_y   (sqValid),
      .m_ready_y   (sqReady),
      .conv_done   (sqDone)
   );

   // Compare one observed value with the value the bench expects.
   task automatic checkOutput(input string name, input int actual, input int expected);
      testsRun++;
      if (actual != expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   // Drive the default instance inputs.
   task automatic applyStimulus(input logic rst, input logic xl, input logic fl, input logic rdy);
      reset   = rst;
      xLoaded = xl;
      fLoaded = fl;
      mReady  = rdy;
   endtask

   // Advance one clock and settle just after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Scoreboard monitor for the default instance, sampled mid-cycle. With
   // RD_LAT=1 the data accumulated in a cycle was addressed the cycle before.
   initial begin : monitor
      issueRec_t exp;
      int        expCyc;
      forever begin
         @(negedge clk);
         if (sbEnable) begin
            if (enAccum) begin
               if (issueQ.size() == 0) begin
                  testsRun++;
                  testsFailed++;
                  $display("[TB] FAIL sb_extra_accum: got en_accum at cycle %0d, expected none", cyc);
               end else begin
                  exp = issueQ.pop_front();
                  checkOutput("sb_x_addr", prevX, exp.xa);
                  checkOutput("sb_f_addr", prevF, exp.fa);
               end
            end
            if (mValid && mReady) begin
               if (hsQ.size() == 0) begin
                  testsRun++;
                  testsFailed++;
                  $display("[TB] FAIL sb_extra_handshake: got handshake at cycle %0d, expected none", cyc);
               end else begin
                  expCyc = hsQ.pop_front();
                  checkOutput("sb_handshake_cycle", cyc, expCyc);
               end
            end
            if (convDone) begin
               doneCount++;
               doneCyc = cyc;
            end
            if (releaseMem) releaseCount++;
         end
         prevX = xRdAddr;
         prevF = fRdAddr;
      end
   end

   initial begin : watchdog
      #100000;
      $display("[TB] FAIL watchdog: got no completion, expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin : main
      int  found;
      int  held;
      int  clears;
      int  n;
      int  seen;
      int  enExp[8];
      int  vExp[8];
      int  sqMaxX;
      int  sqHs;
      int  sqHsCyc;
      int  sqDoneCnt;
      int  sqDoneCyc;

      // Cycle-by-cycle vectors: inputs for a cycle, outputs expected after its edge.
      vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0};
      vecs[1]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0};
      for (int i = 2; i < 10; i++) vecs[i] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0};
      vecs[10] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 0, 0};
      vecs[11] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0};
      vecs[12] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1, 1};
      vecs[13] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2, 2};
      vecs[14] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 3, 3};
      vecs[15] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 3, 3};
      vecs[16] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3, 3};
      vecs[17] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 3, 3};

      enExp = '{0, 0, 0, 1, 1, 1, 1, 0};
      vExp  = '{0, 0, 0, 0, 0, 0, 0, 1};

      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
      l3XLoaded = 1'b0; l3FLoaded = 1'b0; l3Ready = 1'b0;
      sqXLoaded = 1'b0; sqFLoaded = 1'b0; sqReady = 1'b0;
      repeat (3) tick();

      // Reset state
      checkOutput("rst_reset_accum", resetAccum, 0);
      checkOutput("rst_en_accum", enAccum, 0);
      checkOutput("rst_m_valid_y", mValid, 0);
      checkOutput("rst_conv_done", convDone, 0);
      checkOutput("rst_release_mem", releaseMem, 0);
      checkOutput("rst_x_rd_addr", xRdAddr, 0);
      checkOutput("rst_f_rd_addr", fRdAddr, 0);
      checkOutput("rst_l3_valid", l3Valid, 0);
      checkOutput("rst_sq_done", sqDone, 0);

      // Flag gating and the first output, table driven
      for (int i = 0; i < 18; i++) begin
         applyStimulus(1'b0, vecs[i].xl, vecs[i].fl, vecs[i].rdy);
         tick();
         checkOutput($sformatf("vec%0d_reset_accum", i), resetAccum, vecs[i].expReset);
         checkOutput($sformatf("vec%0d_en_accum", i), enAccum, vecs[i].expEn);
         checkOutput($sformatf("vec%0d_m_valid_y", i), mValid, vecs[i].expValid);
         checkOutput($sformatf("vec%0d_x_rd_addr", i), xRdAddr, vecs[i].expX);
         checkOutput($sformatf("vec%0d_f_rd_addr", i), fRdAddr, vecs[i].expF);
         checkOutput($sformatf("vec%0d_conv_done", i), convDone, 0);
      end

      // Backpressure on the second output
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
      tick();
      checkOutput("bp_first_x_addr", xRdAddr, 1);
      found = 0;
      for (int k = 0; k < 20; k++) begin
         if (mValid) begin found = 1; break; end
         tick();
      end
      checkOutput("bp_valid_seen", found, 1);
      held = 0;
      for (int k = 0; k < 7; k++) begin
         mReady = (k == 6);
         if (mValid) held++;
         checkOutput("bp_en_accum_low", enAccum, 0);
         checkOutput("bp_x_addr_held", xRdAddr, 4);
         tick();
      end
      checkOutput("bp_valid_cycles", held, 7);
      checkOutput("bp_valid_dropped", mValid, 0);
      checkOutput("bp_next_clear", resetAccum, 1);
      tick();
      checkOutput("bp_next_out_idx", xRdAddr, 2);
      found = 0;
      for (int k = 0; k < 60; k++) begin
         if (convDone) begin found = 1; break; end
         tick();
      end
      checkOutput("bp_done_seen", found, 1);
      checkOutput("bp_release_with_done", releaseMem, 1);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
      tick();
      checkOutput("bp_done_pulse", convDone, 0);
      checkOutput("bp_release_pulse", releaseMem, 0);
      repeat (3) tick();
      checkOutput("bp_idle_after", resetAccum, 0);

      // Full run scored against the expected address sequence and handshake timing
      sbEnable = 1'b1;
      n = cyc;
      for (int k = 0; k < 5; k++) begin
         for (int t = 0; t < 4; t++) issueQ.push_back('{k + t, t});
         hsQ.push_back(n + 7 + 7 * k);
      end
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b1);
      found = 0;
      for (int k = 0; k < 60; k++) begin
         tick();
         if (releaseMem) begin found = 1; break; end
      end
      checkOutput("sb_release_seen", found, 1);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
      repeat (3) tick();
      sbEnable = 1'b0;
      checkOutput("sb_issues_left", issueQ.size(), 0);
      checkOutput("sb_handshakes_left", hsQ.size(), 0);
      checkOutput("sb_done_count", doneCount, 1);
      checkOutput("sb_release_count", releaseCount, 1);
      checkOutput("sb_done_cycle", doneCyc, n + 36);

      // Reset during MAC of the fourth output
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b1);
      clears = 0;
      for (int k = 0; k < 80; k++) begin
         tick();
         if (resetAccum) clears++;
         if (clears == 4) break;
      end
      checkOutput("mr_fourth_clear", clears, 4);
      tick();
      checkOutput("mr_mac_x_addr", xRdAddr, 3);
      tick();
      checkOutput("mr_mac_x_addr_t1", xRdAddr, 4);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
      tick();
      checkOutput("mr_reset_accum", resetAccum, 0);
      checkOutput("mr_en_accum", enAccum, 0);
      checkOutput("mr_m_valid_y", mValid, 0);
      checkOutput("mr_conv_done", convDone, 0);
      checkOutput("mr_release_mem", releaseMem, 0);
      checkOutput("mr_x_rd_addr", xRdAddr, 0);
      checkOutput("mr_f_rd_addr", fRdAddr, 0);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
      seen = 0;
      for (int k = 0; k < 5; k++) begin
         tick();
         if (convDone || releaseMem || resetAccum || enAccum) seen++;
      end
      checkOutput("mr_stays_idle", seen, 0);
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b1);
      tick();
      checkOutput("mr_restart_clear", resetAccum, 1);
      tick();
      checkOutput("mr_restart_x_addr", xRdAddr, 0);
      checkOutput("mr_restart_f_addr", fRdAddr, 0);
      found = 0;
      for (int k = 0; k < 60; k++) begin
         tick();
         if (releaseMem) begin found = 1; break; end
      end
      checkOutput("mr_release_seen", found, 1);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
      tick();

      // RD_LAT=3 accumulate alignment
      l3Ready = 1'b1; l3XLoaded = 1'b1; l3FLoaded = 1'b1;
      found = 0;
      for (int k = 0; k < 10; k++) begin
         tick();
         if (l3ResetAccum) begin found = 1; break; end
      end
      checkOutput("l3_clear_seen", found, 1);
      for (int k = 0; k < 8; k++) begin
         tick();
         checkOutput($sformatf("l3_en_accum_off%0d", k), l3EnAccum, enExp[k]);
         checkOutput($sformatf("l3_m_valid_off%0d", k), l3Valid, vExp[k]);
      end
      found = 0;
      for (int k = 0; k < 60; k++) begin
         tick();
         if (l3Release) begin found = 1; break; end
      end
      checkOutput("l3_release_seen", found, 1);
      l3XLoaded = 1'b0; l3FLoaded = 1'b0;
      tick();

      // Square memories: exactly one output
      sqReady = 1'b1; sqXLoaded = 1'b1; sqFLoaded = 1'b1;
      sqMaxX = 0; sqHs = 0; sqHsCyc = -1; sqDoneCnt = 0; sqDoneCyc = -1;
      for (int k = 0; k < 30; k++) begin
         tick();
         if (sqXAddr > sqMaxX) sqMaxX = sqXAddr;
         if (sqValid && sqReady) begin sqHs++; sqHsCyc = cyc; end
         if (sqDone) begin sqDoneCnt++; sqDoneCyc = cyc; end
         if (sqRelease) begin sqXLoaded = 1'b0; sqFLoaded = 1'b0; end
      end
      checkOutput("sq_handshakes", sqHs, 1);
      checkOutput("sq_done_count", sqDoneCnt, 1);
      checkOutput("sq_done_after_hs", sqDoneCyc, sqHsCyc + 1);
      checkOutput("sq_max_x_addr", sqMaxX, 3);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule

// File: doc/conv_seq_ctrl.md
Name: conv_seq_ctrl

Overview:
- Top-level sequencer for the convolution datapath.
- Waits until the x and f memory writers report their vectors loaded.
- Then, for each of the N_OUT = X_MEM_SIZE-F_MEM_SIZE+1 outputs, it:
  - issues x/f read addresses,
  - aligns accumulator clear/enable with the memory read latency,
  - presents the result on the AXI-stream y handshake.
- When all outputs are done, it releases both memories for the next vector pair. Sits between the memory write controllers, the x/f memories and the MAC.

Parameters:
X_MEM_SIZE, 8, depth of x memory (input vector length)
F_MEM_SIZE, 4, depth of f memory (filter taps), F_MEM_SIZE <= X_MEM_SIZE
X_MEM_ADDR_WIDTH, 3, x address width, >= clog2(X_MEM_SIZE)
F_MEM_ADDR_WIDTH, 2, f address width, >= clog2(F_MEM_SIZE)
RD_LAT, 1, cycles from read address to data valid at MAC input, 1..4

Ports:
clk  input  1  clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
x_loaded  input  1  level: x memory holds a full vector
f_loaded  input  1  level: f memory holds a full filter
release_mem  output  1  one-cycle pulse: writers may clear loaded flags and reload
x_rd_addr  output  X_MEM_ADDR_WIDTH  x memory read address
f_rd_addr  output  F_MEM_ADDR_WIDTH  f memory read address
reset_accum  output  1  clear accumulator this edge
en_accum  output  1  accumulate MAC product this edge
m_valid_y  output  1  y output valid
m_ready_y  input  1  downstream ready
conv_done  output  1  one-cycle pulse after last y accepted

Behaviour:
- Reset values: state=IDLE, out_idx=0, tap=0, x_rd_addr=0, f_rd_addr=0, en_accum pipe cleared. All 1-bit outputs are 0.
- Reset mid-operation: returns to IDLE next edge. m_valid_y drops without handshake. No release_mem pulse.
- IDLE: all strobes 0.
  - Go to CLEAR when x_loaded && f_loaded are both 1 in the same cycle.
  - One flag high alone keeps IDLE.
- CLEAR, 1 cycle:
  - reset_accum=1; tap=0.
  - x_rd_addr=out_idx, f_rd_addr=0 presented at the end of this cycle.
  - Next state: MAC.
- MAC, exactly F_MEM_SIZE cycles; tap counts 0..F_MEM_SIZE-1.
  - Each cycle issues a read: x_rd_addr=out_idx+tap, f_rd_addr=tap.
  - Each issue enters an RD_LAT-deep shift register; its output is en_accum.
  - en_accum is therefore high exactly F_MEM_SIZE cycles, starting RD_LAT cycles after the first issue.
  - After tap=F_MEM_SIZE-1: go to DRAIN.
- DRAIN, exactly RD_LAT cycles: no new issues; the pipe empties. Then go to OUT.
- OUT:
  - m_valid_y=1, and it holds until m_valid_y && m_ready_y.
  - Accumulator untouched: en_accum=0, reset_accum=0.
  - If m_ready_y is already 1 on the first OUT cycle, the transfer completes that cycle (1-cycle OUT).
  - On handshake with out_idx<N_OUT-1: out_idx++, go to CLEAR (m_valid_y low next cycle).
  - On handshake with out_idx==N_OUT-1: go to DONE.
- DONE, 1 cycle:
  - conv_done=1, release_mem=1, out_idx=0.
  - Go to IDLE.
  - Loaded flags sampled in DONE are ignored; writers must deassert them within one cycle after release_mem.
- Throughput: per output, 1+F_MEM_SIZE+RD_LAT+1 cycles minimum with m_ready_y tied high.
- Address arithmetic:
  - out_idx+tap <= X_MEM_SIZE-1 always. No wrap-around is ever produced.
  - Compute the sum in X_MEM_ADDR_WIDTH+1 bits, then truncate.
- Edge case F_MEM_SIZE==X_MEM_SIZE: N_OUT=1.
- Outputs are registered, except m_valid_y, conv_done and release_mem. Those are decoded from the registered state with no input-to-output combinational path.

Decomposition:
- conv_pkg holds:
  - typedef enum logic [2:0] conv_state_t {IDLE, CLEAR, MAC, DRAIN, OUT, DONE},
  - function n_out(x,f) returning x-f+1.
- One sub-module, valid_delay_line (param DEPTH=RD_LAT): shift register that produces en_accum from the issue strobe, synchronous reset clears it.
- The FSM, counters and address adders stay in conv_seq_ctrl.

Test Plan:
1. Defaults, m_ready_y=1, x_loaded and f_loaded raised together:
   - x_rd_addr sequences 0-3, 1-4, 2-5, 3-6, 4-7, and f_rd_addr 0-3 each time.
   - Exactly 5 m_valid_y handshakes, 7 cycles apart.
   - conv_done and release_mem pulse once, 1 cycle after the 5th handshake.
2. f_loaded at cycle 2, x_loaded at cycle 10 -> stays IDLE until cycle 10. CLEAR (reset_accum=1) at cycle 11.
3. Backpressure: m_ready_y low 6 cycles during output 2 -> m_valid_y held 7 cycles, en_accum=0 throughout, out_idx unchanged until the handshake.
4. RD_LAT=3 -> en_accum rises 3 cycles after the first MAC cycle, stays high exactly 4 cycles, and m_valid_y rises the cycle after DRAIN ends.
5. reset asserted in MAC of output 3 -> next cycle: all outputs 0, state IDLE, no conv_done/release_mem. Reloading flags restarts at out_idx=0.
6. X_MEM_SIZE=4, F_MEM_SIZE=4 -> single output, conv_done after first handshake, x_rd_addr never exceeds 3.
